mipi_frame_checker: RTL

//  Parametrised geometry checker for the unpacked MIPI RAW word stream, sitting after the lane merge and depacker.

---
 rtl/mipi_frame_checker.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mipi_frame_checker.sv
// Line/frame geometry checker for the unpacked MIPI RAW word stream.
// Define MIPI_FRAME_CHK_SUM_EN to add the per-frame XOR checksum output frame_sum.
module mipi_frame_checker #(
    parameter int DATA_W   = 16,
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int CNT_W    = 16,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              raw_vld,
    input  logic [DATA_W-1:0] raw_data,
    input  logic              raw_vsync,
    input  logic              chk_en,
    input  logic              cnt_clr,
    output logic              line_err,
    output logic              frame_err,
    output logic [ERR_W-1:0]  line_err_cnt,
    output logic [ERR_W-1:0]  frame_err_cnt,
    output logic [15:0]       frame_cnt,
    output logic [CNT_W-1:0]  last_line_len,
    output logic [CNT_W-1:0]  last_line_num,
`ifdef MIPI_FRAME_CHK_SUM_EN
    output logic [DATA_W-1:0] frame_sum,
`endif
    output logic              locked
);

    localparam logic [CNT_W-1:0] H_EXP = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_EXP = CNT_W'(V_ACTIVE);

    typedef enum logic {WAIT_SYNC = 1'b0, ACTIVE = 1'b1} state_t;

    state_t            state, state_nxt;
    logic              vld_r, vs_r;
    logic              rise_vs, fall_vld;
    logic              checking, line_close, frame_close;
    logic [CNT_W-1:0]  wc, lc, line_len, line_num;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign rise_vs  = raw_vsync & ~vs_r;
    assign fall_vld = ~raw_vld & vld_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= WAIT_SYNC;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!chk_en) begin
            state_nxt = WAIT_SYNC;
        end else begin
            case (state)
                WAIT_SYNC: if (rise_vs) state_nxt = ACTIVE;
                default:   state_nxt = ACTIVE;
            endcase
        end
    end

    always_comb begin
        locked   = (state == ACTIVE);
        checking = (state == ACTIVE) && chk_en;
    end

    // A line cut by vsync is closed on the vsync beat; the trailing fall of raw_vld
    // then finds wc at zero and must not close a second, empty line.
    always_comb begin
        line_close  = checking && ((rise_vs && vld_r) || (fall_vld && (wc != '0)));
        frame_close = checking && rise_vs;
        line_len    = raw_vld ? sat_inc_cnt(wc) : wc;
        line_num    = line_close ? sat_inc_cnt(lc) : lc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_r         <= 1'b0;
            vs_r          <= 1'b0;
            wc            <= '0;
            lc            <= '0;
            line_err      <= 1'b0;
            frame_err     <= 1'b0;
            line_err_cnt  <= '0;
            frame_err_cnt <= '0;
            frame_cnt     <= '0;
            last_line_len <= '0;
            last_line_num <= '0;
        end else begin
            vld_r     <= raw_vld;
            vs_r      <= raw_vsync;
            line_err  <= line_close && (line_len != H_EXP);
            frame_err <= frame_close && (line_num != V_EXP);

            if (!checking) begin
                wc <= '0;
                lc <= '0;
            end else begin
                if (line_close)   wc <= '0;
                else if (raw_vld) wc <= sat_inc_cnt(wc);
                if (frame_close)     lc <= '0;
                else if (line_close) lc <= sat_inc_cnt(lc);
            end

            if (line_close)  last_line_len <= line_len;
            if (frame_close) last_line_num <= line_num;

            // Clear takes priority over any increment landing in the same cycle.
            if (cnt_clr) begin
                line_err_cnt  <= '0;
                frame_err_cnt <= '0;
                frame_cnt     <= '0;
            end else begin
                if (line_err)    line_err_cnt  <= sat_inc_err(line_err_cnt);
                if (frame_err)   frame_err_cnt <= sat_inc_err(frame_err_cnt);
                if (frame_close) frame_cnt     <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef MIPI_FRAME_CHK_SUM_EN
    logic [DATA_W-1:0] sum_run, beat;

    assign beat = raw_vld ? raw_data : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum_run   <= '0;
            frame_sum <= '0;
        end else if (!checking) begin
            sum_run <= '0;
        end else if (frame_close) begin
            frame_sum <= sum_run ^ beat;
            sum_run   <= '0;
        end else begin
            sum_run <= sum_run ^ beat;
        end
    end
`else
    logic unused_raw_data;
    assign unused_raw_data = ^raw_data;
`endif

endmodule
